// File: rtl/agc_stats_accum.sv
// Windowed sum-of-squares and saturation-count accumulator fed by the AGC DSP stage.
// Define AGC_STATS_OFFSET_EN to add the signed sample sum (sum_o) for DC-offset estimation.
module agc_stats_accum #(
    parameter int NBITS    = 5,
    parameter int CNT_BITS = 24,
    parameter int SQ_BITS  = 2*(NBITS-1)+CNT_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NBITS-1:0]    out_i,
    input  logic [NBITS-2:0]    abs_i,
    input  logic                gt_i,
    input  logic                lt_i,
    input  logic [CNT_BITS-1:0] period_i,
    input  logic                start_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [SQ_BITS-1:0]  sumsq_o,
    output logic [CNT_BITS-1:0] gtcnt_o,
    output logic [CNT_BITS-1:0] ltcnt_o
`ifdef AGC_STATS_OFFSET_EN
    ,
    output logic [SQ_BITS-1:0]  sum_o
`endif
);

    localparam int MAG_BITS = NBITS - 1;
    localparam int SQR_BITS = 2 * MAG_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [CNT_BITS-1:0]   r_count;
    logic [SQ_BITS-1:0]    r_sumsq;
    logic [CNT_BITS-1:0]   r_gtcnt;
    logic [CNT_BITS-1:0]   r_ltcnt;
    logic [SQ_BITS-1:0]    r_sumsq_out;
    logic [CNT_BITS-1:0]   r_gtcnt_out;
    logic [CNT_BITS-1:0]   r_ltcnt_out;

    logic                  w_start_ok;
    logic                  w_last;
    logic [SQR_BITS-1:0]   w_abs_ext;
    logic [SQR_BITS-1:0]   w_sq;
    logic [SQ_BITS-1:0]    w_sumsq_next;
    logic [CNT_BITS-1:0]   w_gtcnt_next;
    logic [CNT_BITS-1:0]   w_ltcnt_next;

    assign w_start_ok = (r_state == ST_IDLE) && start_i && (period_i != '0);
    assign w_last     = (r_state == ST_RUN) && (r_count == CNT_BITS'(1));

    // Squarer feeds the adder directly: one sample per clock, no pipeline stage.
    assign w_abs_ext    = {{MAG_BITS{1'b0}}, abs_i};
    assign w_sq         = w_abs_ext * w_abs_ext;
    assign w_sumsq_next = r_sumsq + {{CNT_BITS{1'b0}}, w_sq};
    assign w_gtcnt_next = r_gtcnt + {{(CNT_BITS-1){1'b0}}, gt_i};
    assign w_ltcnt_next = r_ltcnt + {{(CNT_BITS-1){1'b0}}, lt_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)     w_state_next = ST_HOLD;
            ST_HOLD: if (ack_i)      w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count     <= '0;
            r_sumsq     <= '0;
            r_gtcnt     <= '0;
            r_ltcnt     <= '0;
            r_sumsq_out <= '0;
            r_gtcnt_out <= '0;
            r_ltcnt_out <= '0;
        end else if (w_start_ok) begin
            r_count <= period_i;
            r_sumsq <= '0;
            r_gtcnt <= '0;
            r_ltcnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_count <= r_count - CNT_BITS'(1);
            r_sumsq <= w_sumsq_next;
            r_gtcnt <= w_gtcnt_next;
            r_ltcnt <= w_ltcnt_next;
            // Results include the final sample and are published on the same edge.
            if (w_last) begin
                r_sumsq_out <= w_sumsq_next;
                r_gtcnt_out <= w_gtcnt_next;
                r_ltcnt_out <= w_ltcnt_next;
            end
        end
    end

`ifdef AGC_STATS_OFFSET_EN
    logic [SQ_BITS-1:0] r_sum;
    logic [SQ_BITS-1:0] r_sum_out;
    logic [SQ_BITS-1:0] w_sum_next;

    assign w_sum_next = r_sum + {{(SQ_BITS-NBITS){out_i[NBITS-1]}}, out_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sum     <= '0;
            r_sum_out <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum <= w_sum_next;
            if (w_last) begin
                r_sum_out <= w_sum_next;
            end
        end
    end

    assign sum_o = r_sum_out;
`else
    logic w_unused_out;
    assign w_unused_out = ^out_i;
`endif

    assign busy_o  = (r_state == ST_RUN);
    assign valid_o = (r_state == ST_HOLD);
    assign sumsq_o = r_sumsq_out;
    assign gtcnt_o = r_gtcnt_out;
    assign ltcnt_o = r_ltcnt_out;

endmodule

// File: tb/tb_agc_stats_accum.sv
// Directed bench for agc_stats_accum: a default-width instance plus a CNT_BITS=4 instance
// that exercises the maximum-length, maximum-magnitude window.
module tb_agc_stats_accum;

    localparam int NB  = 5;
    localparam int CB  = 24;
    localparam int SQ  = 2*(NB-1)+CB;
    localparam int CBS = 4;
    localparam int SQS = 2*(NB-1)+CBS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] out_s = '0;
    logic [NB-2:0] abs_s = '0;
    logic          gt_s = 1'b0;
    logic          lt_s = 1'b0;
    logic [CB-1:0] period = '0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [CBS-1:0] period_b = '0;
    logic          start_b = 1'b0;

    logic          busy, valid, busy_b, valid_b;
    logic [SQ-1:0] sumsq;
    logic [CB-1:0] gtcnt, ltcnt;
    logic [SQS-1:0] sumsq_b;
    logic [CBS-1:0] gtcnt_b, ltcnt_b;
`ifdef AGC_STATS_OFFSET_EN
    logic [SQ-1:0]  sum;
    logic [SQS-1:0] sum_b;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    agc_stats_accum #(.NBITS(NB), .CNT_BITS(CB)) dut (
        .clk_i(clk), .rst_i(rst), .out_i(out_s), .abs_i(abs_s), .gt_i(gt_s), .lt_i(lt_s),
        .period_i(period), .start_i(start), .ack_i(ack), .busy_o(busy), .valid_o(valid),
        .sumsq_o(sumsq), .gtcnt_o(gtcnt), .ltcnt_o(ltcnt)
`ifdef AGC_STATS_OFFSET_EN
        , .sum_o(sum)
`endif
    );

    agc_stats_accum #(.NBITS(NB), .CNT_BITS(CBS)) dut_small (
        .clk_i(clk), .rst_i(rst), .out_i(out_s), .abs_i(abs_s), .gt_i(gt_s), .lt_i(lt_s),
        .period_i(period_b), .start_i(start_b), .ack_i(ack), .busy_o(busy_b), .valid_o(valid_b),
        .sumsq_o(sumsq_b), .gtcnt_o(gtcnt_b), .ltcnt_o(ltcnt_b)
`ifdef AGC_STATS_OFFSET_EN
        , .sum_o(sum_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [CB-1:0] p);
        start  = 1'b1;
        period = p;
        tick();
        start  = 1'b0;
    endtask

    task automatic feed(input logic [NB-2:0] a, input logic g, input logic l, input logic [NB-1:0] o);
        abs_s = a;
        gt_s  = g;
        lt_s  = l;
        out_s = o;
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_sumsq", sumsq, 0);
        check("rst_gtcnt", gtcnt, 0);
        check("rst_ltcnt", ltcnt, 0);
        rst = 1'b0;
        tick();

        // N=16, abs=3, gt alternating
        start_win(16);
        check("t1_busy_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            feed(3, (i % 2) == 0, 0, 0);
            if (i == 14) check("t1_valid_early", valid, 0);
        end
        check("t1_valid_at_16", valid, 1);
        check("t1_busy_done", busy, 0);
        check("t1_sumsq", sumsq, 144);
        check("t1_gtcnt", gtcnt, 8);
        check("t1_ltcnt", ltcnt, 0);

        // start during HOLD is ignored
        start = 1'b1; period = 3;
        tick();
        start = 1'b0;
        check("hold_start_valid", valid, 1);
        check("hold_start_sumsq", sumsq, 144);

        // start+ack together in HOLD -> IDLE only
        start = 1'b1; ack = 1'b1; period = 5;
        tick();
        start = 1'b0; ack = 1'b0;
        check("sa_valid", valid, 0);
        check("sa_busy", busy, 0);
        tick();
        check("sa_busy_later", busy, 0);
        check("sa_sumsq_kept", sumsq, 144);

        // start during RUN is ignored
        start_win(4);
        feed(2, 1, 0, 0);
        start = 1'b1; period = 9;
        feed(2, 1, 0, 0);
        start = 1'b0;
        feed(2, 1, 0, 0);
        feed(2, 1, 0, 0);
        check("run_start_valid", valid, 1);
        check("run_start_sumsq", sumsq, 16);
        check("run_start_gtcnt", gtcnt, 4);

        // ack then start next cycle; old values held during new window
        do_ack();
        check("ack_valid", valid, 0);
        start_win(2);
        check("re_busy", busy, 1);
        check("re_held_old", sumsq, 16);
        feed(4, 0, 1, 0);
        check("re_held_mid", sumsq, 16);
        feed(4, 0, 1, 0);
        check("re_valid", valid, 1);
        check("re_sumsq", sumsq, 32);
        check("re_gtcnt", gtcnt, 0);
        check("re_ltcnt", ltcnt, 2);

        // N=1 at max magnitude
        do_ack();
        start_win(1);
        feed(15, 0, 0, 0);
        check("n1_valid", valid, 1);
        check("n1_sumsq", sumsq, 225);

        // period=0 start is ignored
        do_ack();
        start_win(0);
        check("p0_busy", busy, 0);
        tick();
        check("p0_busy_later", busy, 0);
        check("p0_valid", valid, 0);

        // reset mid-window after 7 of 16 samples
        start_win(16);
        for (int i = 0; i < 7; i++) feed(5, 1, 0, 0);
        rst = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", valid, 0);
        check("mr_sumsq", sumsq, 0);
        check("mr_gtcnt", gtcnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_win(16);
        for (int i = 0; i < 16; i++) feed(1, 0, 1, 0);
        check("pr_valid", valid, 1);
        check("pr_sumsq", sumsq, 16);
        check("pr_gtcnt", gtcnt, 0);
        check("pr_ltcnt", ltcnt, 16);
        do_ack();

        // reduced CNT_BITS: N=15 at max magnitude, no wrap
        start_b = 1'b1; period_b = 15;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 15; i++) feed(15, 1, 1, 0);
        check("mx_valid", valid_b, 1);
        check("mx_sumsq", sumsq_b, 3375);
        check("mx_gtcnt", gtcnt_b, 15);
        check("mx_ltcnt", ltcnt_b, 15);
        check("mx_main_idle", busy, 0);
        do_ack();

`ifdef AGC_STATS_OFFSET_EN
        begin
            longint s;
            start_win(4);
            feed(0, 0, 0, 5'b10000);
            feed(0, 0, 0, 5'b01111);
            feed(0, 0, 0, 5'b11111);
            feed(0, 0, 0, 5'b00010);
            s = longint'($signed(sum));
            check("off_sum_zero", s, 0);
            do_ack();
            start_win(8);
            for (int i = 0; i < 8; i++) feed(0, 0, 0, 5'b10000);
            s = longint'($signed(sum));
            check("off_sum_neg", s, -128);
            do_ack();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/agc_stats_accum.md
# agc_stats_accum

Windowed statistics accumulator that sits directly downstream of the AGC DSP stage and consumes its per-sample `abs_o`/`gt_o`/`lt_o` (and optionally `out_o`) outputs. Over a software-programmed window of N samples it accumulates sum-of-squares of the magnitude plus over-/under-threshold counts. It holds the results for the control loop, which computes new scale/offset values and applies them to the DSP stage. One sample per clock, one instance per lane.

## Interface
- `NBITS`, 5: width of the signed output sample from the AGC stage; the magnitude is `NBITS-1` bits.
- `CNT_BITS`, 24: window-length, counter and gt/lt count width.
- `SQ_BITS`, `2*(NBITS-1)+CNT_BITS`: sum-of-squares accumulator width (32 at defaults).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `out_i` in NBITS: signed two's-complement sample (AGC `out_o`); used only with the offset feature.
- `abs_i` in NBITS-1: unsigned magnitude (AGC `abs_o`).
- `gt_i` in 1: sample saturated high (AGC `gt_o`).
- `lt_i` in 1: sample saturated low (AGC `lt_o`).
- `period_i` in CNT_BITS: window length N in samples; sampled on accepted start.
- `start_i` in 1: single-cycle request to begin a window.
- `ack_i` in 1: results consumed; releases the hold.
- `busy_o` out 1: window in progress.
- `valid_o` out 1: results held and stable.
- `sumsq_o` out SQ_BITS: Σ abs².
- `gtcnt_o` out CNT_BITS: count of gt samples.
- `ltcnt_o` out CNT_BITS: count of lt samples.
- `sum_o` out SQ_BITS: signed Σ out_i; present only with `AGC_STATS_OFFSET_EN`.

## Operation
- FSM states: IDLE, RUN, HOLD. Reset → IDLE.
- IDLE: `start_i`=1 and `period_i`≠0 → RUN. On that edge: counter ← `period_i`, all accumulators ← 0. If `start_i`=1 and `period_i`=0, the start is ignored.
- RUN: on every clock, accumulate the current inputs. sumsq += abs_i²; gtcnt += gt_i; ltcnt += lt_i; with the offset feature, sum += sign-extended out_i. Counter decrements.
- RUN with counter=1: the last sample is accumulated. Final values are copied to the output registers on that same edge, and the FSM goes to HOLD.
- HOLD: outputs are frozen and `valid_o`=1. `ack_i`=1 → IDLE. `valid_o` drops next cycle, but output values are retained until the next window completes.
- `start_i` in RUN or HOLD is ignored (not queued). `ack_i` outside HOLD is ignored. With `start_i` and `ack_i` both high in HOLD, only the ack is taken; a new start needs a later cycle.
- The output registers update only on window completion and never show partial sums.
- No overflow is possible: the widths are sized for N ≤ 2^CNT_BITS−1 at maximum magnitude.
- Reset mid-window: the window is aborted, the FSM returns to IDLE, and all accumulators and outputs are cleared.

## Timing
- Reset values: `busy_o`=0, `valid_o`=0, `sumsq_o`=0, `gtcnt_o`=0, `ltcnt_o`=0, `sum_o`=0.
- Start accepted at edge T0. Samples presented in the cycles after edges T0…T0+N−1 are accumulated, so the window is exactly N consecutive samples.
- `busy_o`=1 from T0 until edge T0+N. `valid_o`=1 and outputs are updated from edge T0+N.
- Minimum restart: ack at edge Ta, then a start is accepted at edge Ta+1 or later.
- The squarer is combinational into the accumulator adder: one add per cycle, no extra pipeline.

## Configuration
- `AGC_STATS_OFFSET_EN` defined: the signed sum accumulator and the `sum_o` port are present. It is used for DC-offset estimation (mean = sum_o/N).
- Not defined: the `sum_o` port and its accumulator are removed, and `out_i` is unused.
- All other behaviour is identical in both builds.

## Test plan
- Constant input, N=16: abs_i=3, gt alternating 1/0, lt=0 → `sumsq_o`=144, `gtcnt_o`=8, `ltcnt_o`=0. `valid_o` rises exactly 16 cycles after the start edge.
- Offset build, N=4: out_i sequence −16,15,−1,2 → `sum_o`=0. Then out_i=−16 for N=8 → `sum_o`=−128.
- Boundary conditions:
  - N=1, abs_i=15 → `sumsq_o`=225 after one cycle.
  - `period_i`=0 with start → stays IDLE, `busy_o`=0.
  - Max magnitude for N=2^CNT_BITS−1 (reduced-CNT_BITS bench) → no wrap.
- Handshake:
  - Start pulsed during RUN and during HOLD → no effect on the results.
  - start+ack together in HOLD → IDLE only.
  - Ack then start next cycle → new window; the old values are held until it completes.
- Reset asserted mid-window at sample 7 of 16 → all outputs 0 and IDLE immediately. A subsequent full window gives the correct totals with no residue.
